// File: rtl/redun_mont_seq.sv
// redun_mont_seq -- job sequencer for the redun_mont repeated-squaring core.
//
// Accepts one job {start value, iteration count T} on a valid/ready handshake,
// holds the core in reset, loads it, counts completed squarings on the core's
// valid pulse, captures the core result after exactly T squarings, halts the
// core and presents the result on a valid/ready output.
//
// redun0_t (the core's redundant operand form) is carried as REDUN_W bits.
//
// Optional feature macro: CHKPT_SNAP_EN (adds o_chk_val / o_chk_mul / o_chk_iter
// snapshots every 2**CHKPT_LOG2 iterations).
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_job_val/o_job_rdy     job handshake; i_job_sq start value, i_job_iter T
//   i_abort                 cancel the running job (CRST/LOAD/RUN only)
//   o_res_val/i_res_rdy     result handshake; o_res_mul value after T squarings
//   o_busy                  high whenever not IDLE
//   o_core_rst/sq/val       drive redun_mont i_rst / i_sq / i_val
//   i_core_mul/i_core_val   redun_mont o_mul / o_val (one pulse per squaring)
module redun_mont_seq #(
    parameter int ITER_BITS    = 64,
    parameter int CORE_RST_CYC = 4,
    parameter int REDUN_W      = 64
`ifdef CHKPT_SNAP_EN
    ,
    parameter int CHKPT_LOG2   = 20
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_job_val,
    output logic                 o_job_rdy,
    input  logic [REDUN_W-1:0]   i_job_sq,
    input  logic [ITER_BITS-1:0] i_job_iter,
    input  logic                 i_abort,
    output logic                 o_res_val,
    input  logic                 i_res_rdy,
    output logic [REDUN_W-1:0]   o_res_mul,
    output logic                 o_busy,
    output logic                 o_core_rst,
    output logic [REDUN_W-1:0]   o_core_sq,
    output logic                 o_core_val,
    input  logic [REDUN_W-1:0]   i_core_mul,
    input  logic                 i_core_val
`ifdef CHKPT_SNAP_EN
    ,
    output logic                 o_chk_val,
    output logic [REDUN_W-1:0]   o_chk_mul,
    output logic [ITER_BITS-1:0] o_chk_iter
`endif
);

    localparam int RCW = $clog2(CORE_RST_CYC + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(CORE_RST_CYC - 1);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        CRST = 5'b00010,
        LOAD = 5'b00100,
        RUN  = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [ITER_BITS-1:0] iter_tgt_r;
    logic [ITER_BITS-1:0] iter_cnt_r;
    logic [ITER_BITS-1:0] iter_nxt_s;
    logic [RCW-1:0]       rst_cnt_r;
    logic                 accept_s;
    logic                 abort_s;
    logic                 pulse_s;
    logic                 last_s;

    // Handshake, abort qualification and final-pulse detection.
    always_comb begin
        accept_s   = i_job_val && o_job_rdy;
        abort_s    = i_abort && ((state_r == CRST) || (state_r == LOAD) || (state_r == RUN));
        pulse_s    = (state_r == RUN) && i_core_val;
        // iter_cnt only ever reaches iter_tgt-1 before this compare, so it never wraps.
        iter_nxt_s = iter_cnt_r + ITER_BITS'(1);
        last_s     = pulse_s && (iter_nxt_s == iter_tgt_r);
    end

    // Next-state logic; abort takes priority over the final core pulse.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (i_job_iter == {ITER_BITS{1'b0}}) state_s = DONE;
                    else                                 state_s = CRST;
                end else begin
                    state_s = IDLE;
                end
            end
            CRST: begin
                if (abort_s)                    state_s = IDLE;
                else if (rst_cnt_r == RST_LAST) state_s = LOAD;
                else                            state_s = CRST;
            end
            LOAD: begin
                if (abort_s) state_s = IDLE;
                else         state_s = RUN;
            end
            RUN: begin
                if (abort_s)     state_s = IDLE;
                else if (last_s) state_s = DONE;
                else             state_s = RUN;
            end
            DONE: begin
                if (i_res_rdy) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and state-decoded outputs, registered from the next state
    // so each output is aligned with the state it belongs to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= IDLE;
            o_job_rdy  <= 1'b0;
            o_busy     <= 1'b0;
            o_core_rst <= 1'b1;
            o_core_val <= 1'b0;
            o_res_val  <= 1'b0;
        end else begin
            state_r    <= state_s;
            o_job_rdy  <= (state_s == IDLE);
            o_busy     <= (state_s != IDLE);
            o_core_rst <= !((state_s == LOAD) || (state_s == RUN));
            o_core_val <= (state_s == LOAD);
            o_res_val  <= (state_s == DONE);
        end
    end

    // Core reset hold counter; counts cycles spent in CRST.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_cnt_r <= {RCW{1'b0}};
        end else if (state_r == CRST) begin
            rst_cnt_r <= rst_cnt_r + RCW'(1);
        end else begin
            rst_cnt_r <= {RCW{1'b0}};
        end
    end

    // Job latch, iteration counting and result capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_core_sq  <= {REDUN_W{1'b0}};
            o_res_mul  <= {REDUN_W{1'b0}};
            iter_tgt_r <= {ITER_BITS{1'b0}};
            iter_cnt_r <= {ITER_BITS{1'b0}};
        end else if (accept_s) begin
            // o_core_sq stays put until the next accept: the core samples it late.
            o_core_sq  <= i_job_sq;
            iter_tgt_r <= i_job_iter;
            iter_cnt_r <= {ITER_BITS{1'b0}};
            if (i_job_iter == {ITER_BITS{1'b0}}) begin
                o_res_mul <= i_job_sq;
            end else begin
                o_res_mul <= o_res_mul;
            end
        end else if (pulse_s && !abort_s) begin
            iter_cnt_r <= iter_nxt_s;
            if (last_s) begin
                o_res_mul <= i_core_mul;
            end else begin
                o_res_mul <= o_res_mul;
            end
        end else begin
            iter_cnt_r <= iter_cnt_r;
        end
    end

`ifdef CHKPT_SNAP_EN
    logic chk_hit_s;

    // Checkpoint on every 2**CHKPT_LOG2-th squaring except the final one.
    always_comb begin
        chk_hit_s = pulse_s && !abort_s && !last_s &&
                    (iter_nxt_s[CHKPT_LOG2-1:0] == {CHKPT_LOG2{1'b0}});
    end

    // Checkpoint snapshot registers; o_chk_val is a one-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_chk_val  <= 1'b0;
            o_chk_mul  <= {REDUN_W{1'b0}};
            o_chk_iter <= {ITER_BITS{1'b0}};
        end else if (chk_hit_s) begin
            o_chk_val  <= 1'b1;
            o_chk_mul  <= i_core_mul;
            o_chk_iter <= iter_nxt_s;
        end else begin
            o_chk_val  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed testbench for redun_mont_seq with a small behavioural core model.
// The core model squares modulo 97: first pulse 5 cycles after load, then one
// pulse every 3 cycles, and it stops whenever o_core_rst is high.
module tb_redun_mont_seq;

    localparam logic [63:0] P = 64'd97;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_job_val = 1'b0;
    logic        o_job_rdy;
    logic [63:0] i_job_sq = 64'd0;
    logic [63:0] i_job_iter = 64'd0;
    logic        i_abort = 1'b0;
    logic        o_res_val;
    logic        i_res_rdy = 1'b0;
    logic [63:0] o_res_mul;
    logic        o_busy;
    logic        o_core_rst;
    logic [63:0] o_core_sq;
    logic        o_core_val;
    logic [63:0] i_core_mul;
    logic        i_core_val;
`ifdef CHKPT_SNAP_EN
    logic        o_chk_val;
    logic [63:0] o_chk_mul;
    logic [63:0] o_chk_iter;
`endif

    redun_mont_seq #(
        .ITER_BITS(64), .CORE_RST_CYC(4), .REDUN_W(64)
`ifdef CHKPT_SNAP_EN
        , .CHKPT_LOG2(4)
`endif
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_job_val(i_job_val), .o_job_rdy(o_job_rdy),
        .i_job_sq(i_job_sq), .i_job_iter(i_job_iter), .i_abort(i_abort),
        .o_res_val(o_res_val), .i_res_rdy(i_res_rdy), .o_res_mul(o_res_mul),
        .o_busy(o_busy), .o_core_rst(o_core_rst), .o_core_sq(o_core_sq),
        .o_core_val(o_core_val), .i_core_mul(i_core_mul), .i_core_val(i_core_val)
`ifdef CHKPT_SNAP_EN
        , .o_chk_val(o_chk_val), .o_chk_mul(o_chk_mul), .o_chk_iter(o_chk_iter)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Behavioural core model.
    logic [63:0] m_cur = 64'd0;
    logic [2:0]  m_wait = 3'd0;
    logic        m_act = 1'b0;
    logic        m_val = 1'b0;
    assign i_core_val = m_val;
    assign i_core_mul = m_cur;

    always @(posedge i_clk) begin
        if (o_core_rst) begin
            m_act <= 1'b0;
            m_val <= 1'b0;
        end else if (o_core_val) begin
            m_cur  <= o_core_sq % P;
            m_wait <= 3'd4;
            m_act  <= 1'b1;
            m_val  <= 1'b0;
        end else if (m_act && m_wait == 3'd0) begin
            m_cur  <= (m_cur * m_cur) % P;
            m_val  <= 1'b1;
            m_wait <= 3'd2;
        end else begin
            m_val <= 1'b0;
            if (m_act) m_wait <= m_wait - 3'd1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] sq, input int t);
        logic [63:0] x;
        x = sq % P;
        for (int i = 0; i < t; i++) x = (x * x) % P;
        return x;
    endfunction

    // Per-job observations.
    logic [63:0] r_res;
    bit          r_got, r_idle_ok, r_rst_ok;
    int          r_res_k, r_cv, r_first_cv, r_pulses, r_last_pulse_k, r_rst_rise_k;
    bit          r_hold_bad;
    bit          sq_bad = 1'b0;
    bit          timeout = 1'b0;
    int          r_chk_n;
    logic [31:0] r_chk_iters;
    logic [63:0] r_chk_mul;

    // act: 0 none, 1 abort on pulse act_at, 2 async reset on pulse act_at.
    task automatic run_job(input logic [63:0] sq, input logic [63:0] t,
                           input int act, input int act_at, input int hold);
        int  k, post, w;
        bit  done;
        r_got = 1'b0; r_res = 64'd0; r_res_k = 0; r_cv = 0; r_first_cv = 0;
        r_pulses = 0; r_last_pulse_k = 0; r_rst_rise_k = 0; r_hold_bad = 1'b0;
        r_idle_ok = 1'b0; r_rst_ok = 1'b0; r_chk_n = 0; r_chk_iters = 32'd0; r_chk_mul = 64'd0;
        w = 0;
        while (!o_job_rdy && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_job_rdy) timeout = 1'b1;
        i_job_val = 1'b1; i_job_sq = sq; i_job_iter = t;
        k = 0; post = 0; done = 1'b0;
        while (!done && k < 20000) begin
            @(negedge i_clk);
            k++;
            i_job_val = 1'b0; i_abort = 1'b0; i_res_rdy = 1'b0;
            if (post > 0) begin
                if (i_rst) i_rst = 1'b0;
                if (post == 30 && act == 1) r_idle_ok = !o_busy && o_job_rdy && o_core_rst;
                if (o_res_val) r_got = 1'b1;
                post--;
                if (post == 0) begin
                    if (act == 2) r_idle_ok = !o_busy && o_job_rdy && o_core_rst;
                    done = 1'b1;
                end
            end else begin
                if (o_core_val) begin
                    r_cv++;
                    if (r_first_cv == 0) r_first_cv = k;
                end
                if (o_busy && o_core_sq !== sq) sq_bad = 1'b1;
                if (i_core_val) begin
                    r_pulses++;
                    r_last_pulse_k = k;
                end
                if (r_cv > 0 && o_core_rst && r_rst_rise_k == 0) r_rst_rise_k = k;
`ifdef CHKPT_SNAP_EN
                if (o_chk_val) begin
                    r_chk_n++;
                    r_chk_iters = {r_chk_iters[15:0], o_chk_iter[15:0]};
                    if (r_chk_n == 1) r_chk_mul = o_chk_mul;
                end
`endif
                if (o_res_val) begin
                    if (!r_got) begin
                        r_got = 1'b1; r_res = o_res_mul; r_res_k = k;
                    end else if (o_res_mul !== r_res) begin
                        r_hold_bad = 1'b1;
                    end
                    if (o_job_rdy) r_hold_bad = 1'b1;
                    if (k - r_res_k >= hold) i_res_rdy = 1'b1;
                end else if (r_got) begin
                    done = 1'b1;
                end
                if (act != 0 && i_core_val && r_pulses == act_at) begin
                    post = 30;
                    if (act == 1) begin
                        i_abort = 1'b1;
                    end else begin
                        i_rst = 1'b1;
                        #1;
                        r_rst_ok = o_core_rst && !o_busy && !o_res_val && !o_job_rdy && !o_core_val;
                    end
                end
            end
        end
        if (!done) timeout = 1'b1;
    endtask

    initial begin
        logic [63:0] rsq;
        repeat (3) @(negedge i_clk);
        check_eq("rst_core_rst", {63'd0, o_core_rst}, 64'd1);
        check_eq("rst_job_rdy", {63'd0, o_job_rdy}, 64'd0);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("rst_res_val", {63'd0, o_res_val}, 64'd0);
        check_eq("rst_core_val", {63'd0, o_core_val}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("rdy_after_rst", {63'd0, o_job_rdy}, 64'd1);

        // T=0: result straight from the start value, core never loaded.
        run_job(64'd5, 64'd0, 0, 0, 0);
        check_eq("t0_got", {63'd0, r_got}, 64'd1);
        check_eq("t0_res", r_res, 64'd5);
        check_eq("t0_lat", 64'(r_res_k), 64'd1);
        check_eq("t0_core_val", 64'(r_cv), 64'd0);

        // T=1, sq=3: 3*3 mod 97 = 9.
        run_job(64'd3, 64'd1, 0, 0, 0);
        check_eq("t1_res", r_res, 64'd9);
        check_eq("t1_core_val", 64'(r_cv), 64'd1);
        check_eq("t1_core_val_lat", 64'(r_first_cv), 64'd5);
        check_eq("t1_pulses", 64'(r_pulses), 64'd1);
        check_eq("t1_rst_rise", 64'(r_rst_rise_k), 64'(r_last_pulse_k + 1));

        // T=1000, random start value.
        rsq = 64'($urandom_range(96, 2));
        run_job(rsq, 64'd1000, 0, 0, 0);
        check_eq("t1000_res", r_res, model(rsq, 1000));
        check_eq("t1000_pulses", 64'(r_pulses), 64'd1000);
        check_eq("t1000_rst_rise", 64'(r_rst_rise_k), 64'(r_last_pulse_k + 1));

        // Abort at the 500th pulse, then a fresh job.
        run_job(64'd17, 64'd1000, 1, 500, 0);
        check_eq("abort_no_res", {63'd0, r_got}, 64'd0);
        check_eq("abort_idle", {63'd0, r_idle_ok}, 64'd1);
        run_job(64'd11, 64'd7, 0, 0, 0);
        check_eq("post_abort_res", r_res, model(64'd11, 7));

        // Result held 50 cycles: 4 -> 16 -> 62 -> 61.
        run_job(64'd4, 64'd3, 0, 0, 50);
        check_eq("hold_res", r_res, 64'd61);
        check_eq("hold_stable", {63'd0, r_hold_bad}, 64'd0);

        // Abort coinciding with the final pulse wins.
        run_job(64'd6, 64'd5, 1, 5, 0);
        check_eq("abort_final_no_res", {63'd0, r_got}, 64'd0);
        check_eq("abort_final_idle", {63'd0, r_idle_ok}, 64'd1);

        // Maximum T must not complete early.
        run_job(64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, 0);
        check_eq("tmax_no_res", {63'd0, r_got}, 64'd0);
        check_eq("tmax_pulses", 64'(r_pulses), 64'd3);

        // Asynchronous reset mid-job drops everything.
        run_job(64'd9, 64'd20, 2, 10, 0);
        check_eq("midrst_outputs", {63'd0, r_rst_ok}, 64'd1);
        check_eq("midrst_no_res", {63'd0, r_got}, 64'd0);
        check_eq("midrst_idle", {63'd0, r_idle_ok}, 64'd1);
        run_job(64'd7, 64'd2, 0, 0, 0);
        check_eq("post_rst_res", r_res, model(64'd7, 2));

`ifdef CHKPT_SNAP_EN
        run_job(64'd2, 64'd40, 0, 0, 0);
        check_eq("chk_count", 64'(r_chk_n), 64'd2);
        check_eq("chk_iters", {32'd0, r_chk_iters}, 64'h0000_0000_0010_0020);
        check_eq("chk_mul", r_chk_mul, model(64'd2, 16));
        check_eq("chk_res", r_res, model(64'd2, 40));
`endif

        check_eq("core_sq_stable", {63'd0, sq_bad}, 64'd0);
        check_eq("no_timeout", {63'd0, timeout}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
